multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle opcode/funct decoder in the MIPS processor.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes per state.
- Stalls on a memory ready handshake and halts cleanly on SYSCALL, illegal encodings or memory timeout.
- Keeps a retired-instruction counter.
- Sits between the instruction register and the datapath muxes, register file, PC and memory.

---
 rtl/multicycle_control.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: steps each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes per state, stalls on mem_ready, and halts on
// SYSCALL, illegal encodings or a memory access that never completes.
module multicycle_control #(
  parameter int ALUOP_W     = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrc,
  output logic               WriDataSel,
  output logic               JumpSel,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               halted,
  output logic [1:0]         err,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_NOOP    = 6'b000000;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SLT     = 6'b101010;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_SLT = 6'b101010;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOP = 6'b101100;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Wait counter only has to reach MEM_TIMEOUT; width 1 when the timeout is disabled.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               halted_q, halted_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic               pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic               reg_dst_s, memto_reg_s, alu_src_s, wri_data_sel_s, jump_sel_s;
  logic [1:0]         pc_src_s;
  logic [5:0]         alu_code_s;
  logic               retire_s;
  logic [WAIT_W-1:0]  wait_inc_s;
  logic               timeout_s;

  // Stall-limit detection: this stall cycle would be the MEM_TIMEOUT-th one.
  always_comb begin
    wait_inc_s = wait_q + WAIT_W'(1);
    timeout_s  = (MEM_TIMEOUT != 0) && !mem_ready && (wait_inc_s == TIMEOUT_V);
  end

  // Next-state and per-state datapath controls; everything defaults to idle/no-op.
  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    pc_write_s     = 1'b0;
    ir_write_s     = 1'b0;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    reg_write_s    = 1'b0;
    reg_dst_s      = 1'b0;
    memto_reg_s    = 1'b0;
    alu_src_s      = 1'b0;
    wri_data_sel_s = 1'b0;
    jump_sel_s     = 1'b0;
    pc_src_s       = 2'd0;
    alu_code_s     = ALU_NOP;
    retire_s       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          case (funct)
            F_ADD, F_SUB, F_SLT: state_d = S_EXEC;
            F_JR: begin
              pc_write_s = 1'b1;
              pc_src_s   = 2'd3;
              jump_sel_s = 1'b1;
              retire_s   = 1'b1;
              state_d    = S_FETCH;
            end
            F_NOOP: begin
              retire_s = 1'b1;
              state_d  = S_FETCH;
            end
            F_SYSCALL: begin
              state_d = S_HALT;
              err_d   = ERR_NONE;
            end
            default: begin
              state_d = S_HALT;
              err_d   = ERR_ILLEGAL;
            end
          endcase
        end else begin
          case (opcode)
            OP_LW, OP_SW, OP_BNE, OP_XORI: state_d = S_EXEC;
            OP_J, OP_JAL: begin
              pc_write_s  = 1'b1;
              pc_src_s    = 2'd2;
              reg_write_s = (opcode == OP_JAL);
              retire_s    = 1'b1;
              state_d     = S_FETCH;
            end
            default: begin
              state_d = S_HALT;
              err_d   = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (opcode == OP_RTYPE) begin
          case (funct)
            F_ADD: begin alu_code_s = ALU_ADD; state_d = S_WB; end
            F_SUB: begin alu_code_s = ALU_SUB; state_d = S_WB; end
            F_SLT: begin alu_code_s = ALU_SLT; state_d = S_WB; end
            default: begin
              state_d = S_HALT;
              err_d   = ERR_ILLEGAL;
            end
          endcase
        end else begin
          case (opcode)
            OP_LW, OP_SW: begin
              alu_code_s = ALU_ADD;
              alu_src_s  = 1'b1;
              state_d    = S_MEM;
            end
            OP_XORI: begin
              alu_code_s = ALU_XOR;
              alu_src_s  = 1'b1;
              state_d    = S_WB;
            end
            OP_BNE: begin
              alu_code_s = ALU_SUB;
              if (!zero) begin
                pc_write_s = 1'b1;
                pc_src_s   = 2'd1;
              end else begin
                pc_write_s = 1'b0;
              end
              retire_s = 1'b1;
              state_d  = S_FETCH;
            end
            default: begin
              state_d = S_HALT;
              err_d   = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_MEM: begin
        case (opcode)
          OP_LW: begin
            mem_read_s = 1'b1;
            if (mem_ready) begin
              state_d = S_WB;
            end else if (timeout_s) begin
              state_d = S_HALT;
              err_d   = ERR_TIMEOUT;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_SW: begin
            mem_write_s = 1'b1;
            if (mem_ready) begin
              retire_s = 1'b1;
              state_d  = S_FETCH;
            end else if (timeout_s) begin
              state_d = S_HALT;
              err_d   = ERR_TIMEOUT;
            end else begin
              state_d = S_MEM;
            end
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_WB: begin
        case (opcode)
          OP_RTYPE: begin
            reg_write_s = 1'b1;
            reg_dst_s   = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
          end
          OP_LW: begin
            reg_write_s    = 1'b1;
            memto_reg_s    = 1'b1;
            wri_data_sel_s = 1'b1;
            retire_s       = 1'b1;
            state_d        = S_FETCH;
          end
          OP_XORI: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = ERR_ILLEGAL;
      end
    endcase
  end

  // Bookkeeping: halt flag, saturating retire counter, per-access stall counter.
  always_comb begin
    halted_d = (state_d == S_HALT);
    if (retire_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (state_d != state_q) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
      wait_d = wait_inc_s;
    end else begin
      wait_d = wait_q;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
      cnt_q    <= {CNT_W{1'b0}};
      wait_q   <= {WAIT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
    end
  end

  // ALU code zero-extended to the configured ALUOp width.
  always_comb begin
    ALUOp      = {ALUOP_W{1'b0}};
    ALUOp[5:0] = alu_code_s;
  end

  // Strobes are suppressed while reset is held so an abandoned access has no effect.
  assign PCWrite     = pc_write_s  & ~reset;
  assign IRWrite     = ir_write_s  & ~reset;
  assign MemRead     = mem_read_s  & ~reset;
  assign MemWrite    = mem_write_s & ~reset;
  assign RegWrite    = reg_write_s & ~reset;
  assign RegDst      = reg_dst_s;
  assign MemtoReg    = memto_reg_s;
  assign ALUSrc      = alu_src_s;
  assign WriDataSel  = wri_data_sel_s;
  assign JumpSel     = jump_sel_s;
  assign PCSrc       = pc_src_s;
  assign halted      = halted_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: hand-derived vector table, randomized instruction
// stream against a per-instruction-class model, and corner sequences for halt,
// timeout, saturation and reset.
module tb_multicycle_control;

  localparam logic [5:0] NOP_ALU = 6'b101100;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fst;    // stall cycles on the instruction fetch
    int         mst;    // stall cycles on the data access
    int         lat;
    int         regw;
    int         memw;
    int         memr;
    int         pcw;
    logic [1:0] jsrc;   // PCSrc on a non-fetch PC write
    logic [5:0] alu;    // non-no-op ALUOp seen
    logic [4:0] flags;  // {RegDst,MemtoReg,WriDataSel,JumpSel,ALUSrc} seen
  } vec_t;

  typedef struct {
    int         lat;
    int         regw;
    int         memw;
    int         memr;
    int         pcw;
    logic [1:0] jsrc;
    logic [5:0] alu;
    logic [4:0] flags;
    bit         regw_last;
  } obs_t;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic RegDst, MemtoReg, ALUSrc, WriDataSel, JumpSel;
  logic [1:0] PCSrc, err;
  logic [5:0] ALUOp;
  logic halted;
  logic [31:0] instr_count;

  logic s_PCWrite, s_IRWrite, s_MemRead, s_MemWrite, s_RegWrite;
  logic s_RegDst, s_MemtoReg, s_ALUSrc, s_WriDataSel, s_JumpSel;
  logic [1:0] s_PCSrc, s_err;
  logic [5:0] s_ALUOp;
  logic s_halted;
  logic [1:0] s_instr_count;

  int n_pass = 0;
  int n_total = 0;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .WriDataSel(WriDataSel), .JumpSel(JumpSel), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .halted(halted), .err(err), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2), .MEM_TIMEOUT(4)) u_small (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(s_PCWrite), .IRWrite(s_IRWrite), .MemRead(s_MemRead),
    .MemWrite(s_MemWrite), .RegWrite(s_RegWrite), .RegDst(s_RegDst), .MemtoReg(s_MemtoReg),
    .ALUSrc(s_ALUSrc), .WriDataSel(s_WriDataSel), .JumpSel(s_JumpSel), .PCSrc(s_PCSrc),
    .ALUOp(s_ALUOp), .halted(s_halted), .err(s_err), .instr_count(s_instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected per-instruction behaviour from instruction class, base latency and stalls.
  function automatic vec_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fst, input int mst);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.fst = fst; v.mst = mst;
    v.memr = fst + 1; v.memw = 0; v.regw = 0; v.pcw = 1; v.jsrc = 2'd0;
    v.alu = NOP_ALU; v.flags = 5'b00000; v.lat = fst;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100010, 6'b101010: begin
            v.lat += 4; v.regw = 1; v.alu = fn; v.flags = 5'b10000;
          end
          6'b001000: begin v.lat += 2; v.pcw = 2; v.jsrc = 2'd3; v.flags = 5'b00010; end
          default:   v.lat += 2;
        endcase
      end
      6'b100011: begin
        v.lat += 5 + mst; v.memr += mst + 1; v.regw = 1; v.alu = 6'b100000; v.flags = 5'b01101;
      end
      6'b101011: begin
        v.lat += 4 + mst; v.memw = mst + 1; v.alu = 6'b100000; v.flags = 5'b00001;
      end
      6'b000101: begin
        v.lat += 3; v.alu = 6'b100010;
        if (!z) begin v.pcw = 2; v.jsrc = 2'd1; end
      end
      6'b001110: begin v.lat += 4; v.regw = 1; v.alu = 6'b100110; v.flags = 5'b00001; end
      6'b000010: begin v.lat += 2; v.pcw = 2; v.jsrc = 2'd2; end
      default:   begin v.lat += 2; v.pcw = 2; v.jsrc = 2'd2; v.regw = 1; end
    endcase
    return v;
  endfunction

  // Runs one instruction from FETCH until it retires or the core halts.
  task automatic run_instr(input string tag, input vec_t v, output obs_t o);
    int acc = 0;
    int st = 0;
    int cyc = 0;
    bit access;
    bit done = 1'b0;
    logic [31:0] c0;
    o.lat = 0; o.regw = 0; o.memw = 0; o.memr = 0; o.pcw = 0;
    o.jsrc = 2'd0; o.alu = NOP_ALU; o.flags = 5'b00000; o.regw_last = 1'b0;
    c0 = instr_count;
    opcode = v.op; funct = v.fn; zero = v.z;
    while (!done) begin
      @(negedge clk);
      access = MemRead || MemWrite;
      if (access) mem_ready = (st >= ((acc == 0) ? v.fst : v.mst));
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (MemRead) o.memr++;
      if (MemWrite) o.memw++;
      if (RegWrite) o.regw++;
      o.regw_last = RegWrite;
      if (PCWrite) begin
        o.pcw++;
        if (!IRWrite) o.jsrc = PCSrc;
      end
      if (ALUOp != NOP_ALU) o.alu = ALUOp;
      o.flags = o.flags | {RegDst, MemtoReg, WriDataSel, JumpSel, ALUSrc};
      @(posedge clk);
      cyc++;
      if (access) begin
        if (mem_ready) begin acc++; st = 0; end
        else st++;
      end
      #1;
      if ((instr_count != c0) || halted) done = 1'b1;
      else if (cyc >= 200) begin
        done = 1'b1;
        n_total++;
        $display("FAIL %s.budget: no retire or halt after %0d cycles", tag, cyc);
      end
    end
    o.lat = cyc;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".lat"},   o.lat,  v.lat);
    chk({tag, ".regw"},  o.regw, v.regw);
    chk({tag, ".rwlast"}, o.regw_last, (v.regw > 0) ? 1 : 0);
    chk({tag, ".memw"},  o.memw, v.memw);
    chk({tag, ".memr"},  o.memr, v.memr);
    chk({tag, ".pcw"},   o.pcw,  v.pcw);
    chk({tag, ".pcsrc"}, o.jsrc, v.jsrc);
    chk({tag, ".aluop"}, o.alu,  v.alu);
    chk({tag, ".flags"}, o.flags, v.flags);
    chk({tag, ".halted"}, halted, 0);
  endtask

  // Holds reset for three edges, checks strobes are gated, releases just after an edge.
  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 0);
    chk("rst.s_strobes", {s_PCWrite, s_IRWrite, s_RegWrite, s_MemWrite}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst.count", instr_count, 0);
    chk("rst.halted", halted, 0);
    chk("rst.err", err, 0);
  endtask

  vec_t tbl [12];
  logic [5:0] kind_op [12];
  logic [5:0] kind_fn [12];

  initial begin
    vec_t v;
    obs_t o;
    int exp_cnt;
    int viol;
    int k;

    tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 0, 1, 1, 2'd0, 6'b100000, 5'b10000};
    tbl[1]  = '{6'b000000, 6'b100010, 1'b1, 2, 0, 6, 1, 0, 3, 1, 2'd0, 6'b100010, 5'b10000};
    tbl[2]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1, 0, 1, 1, 2'd0, 6'b101010, 5'b10000};
    tbl[3]  = '{6'b100011, 6'b001100, 1'b0, 0, 3, 8, 1, 0, 5, 1, 2'd0, 6'b100000, 5'b01101};
    tbl[4]  = '{6'b101011, 6'b000000, 1'b0, 1, 2, 7, 0, 3, 2, 1, 2'd0, 6'b100000, 5'b00001};
    tbl[5]  = '{6'b000101, 6'b111111, 1'b0, 0, 0, 3, 0, 0, 1, 2, 2'd1, 6'b100010, 5'b00000};
    tbl[6]  = '{6'b000101, 6'b000000, 1'b1, 0, 0, 3, 0, 0, 1, 1, 2'd0, 6'b100010, 5'b00000};
    tbl[7]  = '{6'b001110, 6'b001000, 1'b0, 1, 0, 5, 1, 0, 2, 1, 2'd0, 6'b100110, 5'b00001};
    tbl[8]  = '{6'b000010, 6'b001100, 1'b0, 0, 0, 2, 0, 0, 1, 2, 2'd2, NOP_ALU,   5'b00000};
    tbl[9]  = '{6'b000011, 6'b000000, 1'b0, 0, 0, 2, 1, 0, 1, 2, 2'd2, NOP_ALU,   5'b00000};
    tbl[10] = '{6'b000000, 6'b001000, 1'b0, 3, 0, 5, 0, 0, 4, 2, 2'd3, NOP_ALU,   5'b00010};
    tbl[11] = '{6'b000000, 6'b000000, 1'b0, 0, 0, 2, 0, 0, 1, 1, 2'd0, NOP_ALU,   5'b00000};
    for (int i = 0; i < 12; i++) begin
      kind_op[i] = tbl[i].op;
      kind_fn[i] = tbl[i].fn;
    end

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 6'b000000; funct = 6'b100000;
    do_reset();

    // Table of hand-derived vectors
    for (int i = 0; i < 12; i++) begin
      run_instr($sformatf("tbl%0d", i), tbl[i], o);
      check_vec($sformatf("tbl%0d", i), tbl[i], o);
    end
    chk("tbl.count", instr_count, 12);
    chk("sat.count", s_instr_count, 3);
    chk("sat.halted", s_halted, 0);

    // Randomized instruction stream against the model
    exp_cnt = 12;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 11);
      v = model(kind_op[k], (kind_op[k] == 6'b000000) ? kind_fn[k] : 6'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr($sformatf("rnd%0d", i), v, o);
      check_vec($sformatf("rnd%0d", i), v, o);
      exp_cnt++;
    end
    chk("rnd.count", instr_count, exp_cnt);
    chk("rnd.s_count", s_instr_count, 3);

    // Reset in the middle of a stalled fetch
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("midrst.strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 0);
    chk("midrst.s_strobes", {s_PCWrite, s_IRWrite, s_RegWrite, s_MemWrite}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.count", instr_count, 0);
    chk("midrst.s_count", s_instr_count, 0);
    v = model(6'b000000, 6'b100000, 1'b0, 3, 0);
    run_instr("midrst.add", v, o);
    check_vec("midrst.add", v, o);
    chk("midrst.s_halted", s_halted, 0);
    chk("midrst.s_count1", s_instr_count, 1);

    // SYSCALL halts cleanly and stays halted
    v = model(6'b000000, 6'b001100, 1'b0, 0, 0);
    run_instr("syscall", v, o);
    chk("syscall.lat", o.lat, 2);
    chk("syscall.halted", halted, 1);
    chk("syscall.err", err, 0);
    chk("syscall.count", instr_count, 1);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom_range(0, 1));
      #1;
      if (!halted || (err != 2'd0) || PCWrite || IRWrite || MemRead || MemWrite || RegWrite)
        viol++;
    end
    @(posedge clk); #1;
    chk("syscall.hold", viol, 0);
    chk("syscall.count2", instr_count, 1);

    // Illegal opcode and illegal funct
    do_reset();
    v = model(6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr("illop", v, o);
    chk("illop.halted", halted, 1);
    chk("illop.err", err, 1);
    chk("illop.count", instr_count, 0);
    do_reset();
    v = model(6'b000000, 6'b111111, 1'b0, 0, 0);
    run_instr("illfn", v, o);
    chk("illfn.halted", halted, 1);
    chk("illfn.err", err, 1);

    // Fetch timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tmo.before", s_halted, 0);
    @(posedge clk); #1;
    chk("tmo.halted", s_halted, 1);
    chk("tmo.err", s_err, 2);
    chk("tmo.main", halted, 0);
    chk("tmo.ctrl", {s_PCWrite, s_IRWrite, s_MemRead, s_MemWrite, s_RegWrite, s_RegDst,
                     s_MemtoReg, s_ALUSrc, s_WriDataSel, s_JumpSel, s_PCSrc}, 0);
    chk("tmo.aluop", s_ALUOp, NOP_ALU);

    // Three stalls are tolerated
    do_reset();
    v = model(6'b000000, 6'b100000, 1'b0, 3, 0);
    run_instr("tmo3", v, o);
    chk("tmo3.lat", o.lat, 7);
    chk("tmo3.s_halted", s_halted, 0);
    chk("tmo3.s_count", s_instr_count, 1);

    // Data-access timeout on a load
    do_reset();
    v = model(6'b100011, 6'b000000, 1'b0, 0, 4);
    run_instr("tmomem", v, o);
    check_vec("tmomem", v, o);
    chk("tmomem.s_halted", s_halted, 1);
    chk("tmomem.s_err", s_err, 2);
    chk("tmomem.s_count", s_instr_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
